// File: rtl/pwm_dac_if.sv
// Sample handshake between the sine lookup stage and the PWM DAC.
// The producer drives amp/amp_valid; the DAC answers with amp_ready.
interface pwm_dac_if;
   logic [7:0] amp;
   logic       amp_valid;
   logic       amp_ready;

   modport master (
      output amp,
      output amp_valid,
      input  amp_ready
   );

   modport slave (
      input  amp,
      input  amp_valid,
      output amp_ready
   );
endinterface

// File: rtl/pwm_dac.sv
// PWM DAC stage: double-buffers one 8-bit sample, emits a sample request each
// PWM period and flags underruns when no fresh sample is waiting at a boundary.
module pwm_dac #(
   parameter int unsigned CLK_DIV = 1
) (
   input  logic     clk_in,
   input  logic     rst_n_in,
   input  logic     enable_in,
   input  logic     clear_in,
   pwm_dac_if.slave amp_bus,
   output logic     pwm_out,
   output logic     sample_req_out,
   output logic     underrun_out
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [15:0] TICK_LAST = 16'(CLK_DIV - 1);

   state_t      state_r;
   state_t      state_next;
   logic [15:0] presc_r;
   logic [15:0] presc_next;
   logic [7:0]  cnt_r;
   logic [7:0]  cnt_next;
   logic [7:0]  duty_r;
   logic [7:0]  hold_r;
   logic        hold_full;

   logic        start;
   logic        tick;
   logic        wrap;
   logic        boundary;
   logic        accept;
   logic        run_next;
   logic        pwm_next;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next;
      end
   end

   always_comb begin
      state_next = state_r;
      case (state_r)
         IDLE:    if (enable_in)  state_next = RUN;
         RUN:     if (!enable_in) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Dropping enable_in leaves RUN at once, so the counters and pwm_out are
   // zeroed on that same edge rather than waiting for the period to end.
   always_comb begin
      start      = (state_r == IDLE) && enable_in;
      tick       = (state_r == RUN) && (presc_r == TICK_LAST);
      wrap       = tick && (cnt_r == 8'hFF);
      boundary   = start || wrap;
      accept     = amp_bus.amp_valid && !hold_full;
      run_next   = (state_r == RUN) && enable_in;
      presc_next = 16'd0;
      cnt_next   = 8'd0;
      if (run_next) begin
         presc_next = tick ? 16'd0 : presc_r + 16'd1;
         cnt_next   = tick ? cnt_r + 8'd1 : cnt_r;
      end
      pwm_next = run_next && (cnt_r < duty_r);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         presc_r        <= 16'd0;
         cnt_r          <= 8'd0;
         pwm_out        <= 1'b0;
         sample_req_out <= 1'b0;
      end else begin
         presc_r        <= presc_next;
         cnt_r          <= cnt_next;
         pwm_out        <= pwm_next;
         sample_req_out <= boundary;
      end
   end

   // Boundary decisions look at hold_full before this edge, so a sample
   // accepted on a boundary edge with an empty hold waits a full period.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         duty_r    <= 8'd0;
         hold_r    <= 8'd0;
         hold_full <= 1'b0;
      end else begin
         if (boundary && hold_full) begin
            duty_r    <= hold_r;
            hold_full <= 1'b0;
         end else if (start) begin
            duty_r <= 8'd0;
         end
         if (accept) begin
            hold_r    <= amp_bus.amp;
            hold_full <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         underrun_out <= 1'b0;
      end else if (wrap && !hold_full) begin
         underrun_out <= 1'b1;
      end else if (clear_in) begin
         underrun_out <= 1'b0;
      end
   end

   assign amp_bus.amp_ready = ~hold_full;

endmodule

// File: tb/tb_pwm_dac.sv
// Directed bench for pwm_dac: reset/handshake vector table, then multi-period
// sequences for duty extremes, underrun, backpressure, disable and reset.
module tb_pwm_dac;

   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic rst_n_in;
   logic enable_in;
   logic clear_in;
   logic pwm_out;
   logic sample_req_out;
   logic underrun_out;

   logic enable3;
   logic clear3;
   logic pwm3;
   logic req3;
   logic und3;

   pwm_dac_if bus ();
   pwm_dac_if bus3 ();

   pwm_dac #(.CLK_DIV(1)) dut (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .enable_in     (enable_in),
      .clear_in      (clear_in),
      .amp_bus       (bus),
      .pwm_out       (pwm_out),
      .sample_req_out(sample_req_out),
      .underrun_out  (underrun_out)
   );

   pwm_dac #(.CLK_DIV(3)) dut3 (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .enable_in     (enable3),
      .clear_in      (clear3),
      .amp_bus       (bus3),
      .pwm_out       (pwm3),
      .sample_req_out(req3),
      .underrun_out  (und3)
   );

   typedef struct {
      string      name;
      logic       rst;
      logic       en;
      logic       valid;
      logic [7:0] amp;
      logic       clr;
      logic       pwm;
      logic       req;
      logic       und;
      logic       rdy;
   } vec_t;

   typedef struct {
      int   highs;
      int   reqCount;
      int   reqIdx;
      int   readyHighs;
      logic undMid;
      logic undEnd;
      logic readyEnd;
   } meas_t;

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic en, input logic valid,
                                input logic [7:0] amp, input logic clr);
      rst_n_in      = rst;
      enable_in     = en;
      bus.amp_valid = valid;
      bus.amp       = amp;
      clear_in      = clr;
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      step();
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      step();
   endtask

   task automatic loadAndStart(input logic [7:0] amp);
      applyStimulus(1'b1, 1'b0, 1'b1, amp, 1'b0);
      step();
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
      step();
      checkOutput("start_req", int'(sample_req_out), 1);
   endtask

   // One full 256-clock period of dut, started right after a boundary edge.
   // feedAt/clearAt: 0 = never, <0 = every clock, k = only before edge k.
   task automatic measurePeriod(input int feedAt, input logic [7:0] feedAmp,
                                input int clearAt, output meas_t m);
      m.highs = 0; m.reqCount = 0; m.reqIdx = 0; m.readyHighs = 0;
      m.undMid = 1'b0; m.undEnd = 1'b0; m.readyEnd = 1'b0;
      for (int i = 1; i <= 256; i++) begin
         bus.amp_valid = (feedAt < 0) || (feedAt == i);
         bus.amp       = feedAmp;
         clear_in      = (clearAt < 0) || (clearAt == i);
         step();
         if (pwm_out) m.highs++;
         if (sample_req_out) begin
            m.reqCount++;
            m.reqIdx = i;
         end
         if (bus.amp_ready) m.readyHighs++;
         if (i == 128) m.undMid = underrun_out;
         if (i == 256) begin
            m.undEnd   = underrun_out;
            m.readyEnd = bus.amp_ready;
         end
      end
      bus.amp_valid = 1'b0;
      clear_in      = 1'b0;
   endtask

   vec_t  vecs[8];
   meas_t m;

   initial begin
      vecs[0] = '{"reset_held",         1'b0, 1'b1, 1'b1, 8'd77,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{"idle_after_reset",   1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{"accept_idle",        1'b1, 1'b0, 1'b1, 8'd128, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{"backpressure_idle",  1'b1, 1'b0, 1'b1, 8'd33,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{"start",              1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{"first_high",         1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{"accept_run",         1'b1, 1'b1, 1'b1, 8'd64,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{"disable_clears_pwm", 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      enable3        = 1'b0;
      clear3         = 1'b0;
      bus3.amp_valid = 1'b0;
      bus3.amp       = 8'd0;
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

      // Random inputs while reset is held must not disturb anything.
      for (int r = 0; r < 5; r++) begin
         applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         step();
         checkOutput("rand_reset_pwm", int'(pwm_out), 0);
         checkOutput("rand_reset_rdy", int'(bus.amp_ready), 1);
      end

      for (int v = 0; v < 8; v++) begin
         applyStimulus(vecs[v].rst, vecs[v].en, vecs[v].valid, vecs[v].amp, vecs[v].clr);
         step();
         checkOutput({vecs[v].name, "_pwm"}, int'(pwm_out), int'(vecs[v].pwm));
         checkOutput({vecs[v].name, "_req"}, int'(sample_req_out), int'(vecs[v].req));
         checkOutput({vecs[v].name, "_und"}, int'(underrun_out), int'(vecs[v].und));
         checkOutput({vecs[v].name, "_rdy"}, int'(bus.amp_ready), int'(vecs[v].rdy));
      end

      // Duty 128 fed every period.
      doReset();
      loadAndStart(8'd128);
      for (int p = 0; p < 10; p++) begin
         measurePeriod(1, 8'd128, 0, m);
         checkOutput("duty128_highs", m.highs, 128);
         checkOutput("duty128_req_count", m.reqCount, 1);
         checkOutput("duty128_req_idx", m.reqIdx, 256);
      end
      checkOutput("duty128_no_underrun", int'(underrun_out), 0);

      // Extremes, then starve the stage to provoke underruns.
      doReset();
      loadAndStart(8'd0);
      measurePeriod(1, 8'd255, 0, m);
      checkOutput("duty0_highs", m.highs, 0);
      measurePeriod(1, 8'd64, 0, m);
      checkOutput("duty255_highs", m.highs, 255);
      checkOutput("duty255_und", int'(m.undEnd), 0);
      measurePeriod(0, 8'd0, 0, m);
      checkOutput("duty64_highs", m.highs, 64);
      checkOutput("underrun_set", int'(m.undEnd), 1);
      measurePeriod(0, 8'd0, 10, m);
      checkOutput("duty_kept_highs", m.highs, 64);
      checkOutput("clear_pulse", int'(m.undMid), 0);
      checkOutput("underrun_again", int'(m.undEnd), 1);
      measurePeriod(0, 8'd0, -1, m);
      checkOutput("clear_held_mid", int'(m.undMid), 0);
      checkOutput("set_wins_over_clear", int'(m.undEnd), 1);

      // Continuous valid: one acceptance per period.
      doReset();
      loadAndStart(8'd100);
      measurePeriod(-1, 8'd200, 0, m);
      checkOutput("bp_p1_highs", m.highs, 100);
      checkOutput("bp_p1_ready_once", m.readyHighs, 1);
      measurePeriod(-1, 8'd200, 0, m);
      checkOutput("bp_p2_highs", m.highs, 200);
      checkOutput("bp_p2_ready_once", m.readyHighs, 1);
      checkOutput("bp_no_underrun", int'(m.undEnd), 0);
      measurePeriod(256, 8'd150, 0, m);
      checkOutput("late_sample_highs", m.highs, 200);
      checkOutput("late_sample_underrun", int'(m.undEnd), 1);
      checkOutput("late_sample_held", int'(m.readyEnd), 0);
      measurePeriod(0, 8'd0, 0, m);
      checkOutput("late_sample_duty_kept", m.highs, 200);
      measurePeriod(0, 8'd0, 0, m);
      checkOutput("late_sample_used", m.highs, 150);

      // Disable mid-period at cnt_r = 50, then re-enable.
      doReset();
      loadAndStart(8'd128);
      for (int i = 1; i <= 50; i++) begin
         bus.amp_valid = (i == 1);
         bus.amp       = 8'd90;
         step();
      end
      bus.amp_valid = 1'b0;
      enable_in     = 1'b0;
      step();
      checkOutput("disable_pwm_low", int'(pwm_out), 0);
      checkOutput("disable_hold_kept", int'(bus.amp_ready), 0);
      repeat (3) step();
      checkOutput("idle_pwm_low", int'(pwm_out), 0);
      enable_in = 1'b1;
      step();
      checkOutput("reenable_req", int'(sample_req_out), 1);
      checkOutput("reenable_drains", int'(bus.amp_ready), 1);
      measurePeriod(0, 8'd0, 0, m);
      checkOutput("reenable_duty90", m.highs, 90);

      // Asynchronous reset between edges while running.
      bus.amp_valid = 1'b1;
      bus.amp       = 8'd5;
      step();
      bus.amp_valid = 1'b0;
      checkOutput("pre_reset_pwm", int'(pwm_out), 1);
      checkOutput("pre_reset_und", int'(underrun_out), 1);
      #2;
      rst_n_in = 1'b0;
      #1;
      checkOutput("async_reset_pwm", int'(pwm_out), 0);
      checkOutput("async_reset_und", int'(underrun_out), 0);
      checkOutput("async_reset_rdy", int'(bus.amp_ready), 1);
      rst_n_in = 1'b1;
      step();
      checkOutput("start_empty_req", int'(sample_req_out), 1);
      checkOutput("start_empty_no_flag", int'(underrun_out), 0);
      measurePeriod(0, 8'd0, 0, m);
      checkOutput("start_empty_duty0", m.highs, 0);

      // CLK_DIV = 3, duty 10: 30 high clocks in a 768-clock period.
      doReset();
      bus3.amp_valid = 1'b1;
      bus3.amp       = 8'd10;
      step();
      bus3.amp_valid = 1'b0;
      checkOutput("div3_accept", int'(bus3.amp_ready), 0);
      enable3 = 1'b1;
      step();
      checkOutput("div3_start_req", int'(req3), 1);
      begin
         int highs3 = 0;
         int reqs3  = 0;
         int reqIdx3 = 0;
         for (int i = 1; i <= 768; i++) begin
            step();
            if (pwm3) highs3++;
            if (req3) begin
               reqs3++;
               reqIdx3 = i;
            end
         end
         checkOutput("div3_highs", highs3, 30);
         checkOutput("div3_req_count", reqs3, 1);
         checkOutput("div3_req_idx", reqIdx3, 768);
      end
      checkOutput("div3_underrun", int'(und3), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
